apb_pwm_out: RTL and testbench



---
 rtl/apb_pwm_pkg.sv | 26 ++
 rtl/apb_pwm_out_pwm_core.sv | 69 ++++++
 rtl/apb_pwm_out.sv | 113 +++++++++++
 tb/tb_apb_pwm_out.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pwm_pkg.sv
// Shared definitions for the APB PWM output peripheral.
//   - register word indices (PADDR[4:2]) and byte offsets
//   - CTRL bit positions
//   - default value width for period, duty and counter
package apb_pwm_pkg;

    localparam int DATA_WIDTH_DEF = 12;

    typedef enum logic [2:0] {
        REG_CTRL   = 3'd0,
        REG_PERIOD = 3'd1,
        REG_DUTY   = 3'd2,
        REG_CNT    = 3'd3,
        REG_STATUS = 3'd4
    } reg_idx_e;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_PERIOD = 12'h004;
    localparam logic [11:0] OFF_DUTY   = 12'h008;
    localparam logic [11:0] OFF_CNT    = 12'h00C;
    localparam logic [11:0] OFF_STATUS = 12'h010;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_POL = 1;

endpackage

// File: rtl/apb_pwm_out_pwm_core.sv
// PWM engine: counter, shadow period/duty registers, wrap pulse, output flop.
// Ports:
//   clk, RSTn          clock, async active-low reset
//   en_nxt, pol_nxt    value CTRL.EN / CTRL.POL take on at the coming edge
//   per_buf, duty_buf  software-side buffer registers
//   cnt                live counter
//   wrap               1 on a cycle whose edge ends a period
//   pwm_out            registered PWM output
module pwm_core
    import apb_pwm_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  RSTn,
    input  logic                  en_nxt,
    input  logic                  pol_nxt,
    input  logic [DATA_WIDTH-1:0] per_buf,
    input  logic [DATA_WIDTH-1:0] duty_buf,
    output logic [DATA_WIDTH-1:0] cnt,
    output logic                  wrap,
    output logic                  pwm_out
);

    logic                  en_q;
    logic                  rise;
    logic                  run;
    logic                  active;
    logic [DATA_WIDTH-1:0] per_s;
    logic [DATA_WIDTH-1:0] dut_s;

    // Using the next-state enable lets the enabling CTRL write load the
    // shadows and clear the counter on its own commit edge.
    assign rise   = en_nxt & ~en_q;
    assign run    = en_nxt & en_q;
    assign wrap   = run & (cnt == per_s);
    assign active = cnt < dut_s;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            en_q    <= 1'b0;
            cnt     <= '0;
            per_s   <= '0;
            dut_s   <= '0;
            pwm_out <= 1'b0;
        end else begin
            en_q <= en_nxt;
            if (!en_nxt) begin
                cnt     <= '0;
                pwm_out <= pol_nxt;
            end else if (rise) begin
                cnt     <= '0;
                per_s   <= per_buf;
                dut_s   <= duty_buf;
                pwm_out <= pol_nxt;
            end else begin
                pwm_out <= active ^ pol_nxt;
                if (wrap) begin
                    cnt   <= '0;
                    per_s <= per_buf;
                    dut_s <= duty_buf;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/apb_pwm_out.sv
// APB slave driving a double-buffered PWM output pin.
// Ports:
//   PCLK, PRESETn      clock, async active-low reset
//   PSEL .. PWDATA     APB request (PADDR[4:2] decoded)
//   PRDATA, PREADY     read data (registered at end of setup), always ready
//   PSLVERR            error on undecoded offsets 0x14-0x1C
//   pwm_out            PWM pin
module apb_pwm_out
    import apb_pwm_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [11:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        pwm_out
);

    logic [2:0]            idx;
    logic                  wr;
    logic                  setup;
    logic                  bad;
    logic                  ctrl_en;
    logic                  ctrl_pol;
    logic                  en_nxt;
    logic                  pol_nxt;
    logic [DATA_WIDTH-1:0] per_buf;
    logic [DATA_WIDTH-1:0] duty_buf;
    logic [DATA_WIDTH-1:0] cnt;
    logic                  wrap;
    logic                  wrap_st;
    logic [31:0]           rd_val;
    logic                  unused_bits;

    assign unused_bits = &{1'b0, PADDR[11:5], PADDR[1:0], PWDATA[31:DATA_WIDTH]};

    assign idx    = PADDR[4:2];
    assign wr     = PSEL & PENABLE & PWRITE;
    assign setup  = PSEL & ~PENABLE;
    assign bad    = idx > REG_STATUS;
    assign PREADY = 1'b1;

    always_comb begin
        en_nxt  = ctrl_en;
        pol_nxt = ctrl_pol;
        if (wr && idx == REG_CTRL) begin
            en_nxt  = PWDATA[CTRL_EN];
            pol_nxt = PWDATA[CTRL_POL];
        end
    end

    always_comb begin
        rd_val = '0;
        case (idx)
            REG_CTRL: begin
                rd_val[CTRL_EN]  = ctrl_en;
                rd_val[CTRL_POL] = ctrl_pol;
            end
            REG_PERIOD: rd_val[DATA_WIDTH-1:0] = per_buf;
            REG_DUTY:   rd_val[DATA_WIDTH-1:0] = duty_buf;
            REG_CNT:    rd_val[DATA_WIDTH-1:0] = cnt;
            REG_STATUS: rd_val[0] = wrap_st;
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_en  <= 1'b0;
            ctrl_pol <= 1'b0;
            per_buf  <= '0;
            duty_buf <= '0;
            wrap_st  <= 1'b0;
            PRDATA   <= '0;
            PSLVERR  <= 1'b0;
        end else begin
            ctrl_en  <= en_nxt;
            ctrl_pol <= pol_nxt;
            if (wr && idx == REG_PERIOD) per_buf  <= PWDATA[DATA_WIDTH-1:0];
            if (wr && idx == REG_DUTY)   duty_buf <= PWDATA[DATA_WIDTH-1:0];

            // A wrap on the same edge as a W1C keeps the flag set.
            if (wrap)
                wrap_st <= 1'b1;
            else if (wr && idx == REG_STATUS && PWDATA[0])
                wrap_st <= 1'b0;

            // Captured at the end of setup, held through access, then cleared.
            PRDATA  <= (setup && !PWRITE) ? rd_val : 32'd0;
            PSLVERR <= setup & bad;
        end
    end

    pwm_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .clk      (PCLK),
        .RSTn     (PRESETn),
        .en_nxt   (en_nxt),
        .pol_nxt  (pol_nxt),
        .per_buf  (per_buf),
        .duty_buf (duty_buf),
        .cnt      (cnt),
        .wrap     (wrap),
        .pwm_out  (pwm_out)
    );

endmodule

// File: tb/tb_apb_pwm_out.sv
// Bench for apb_pwm_out: per-cycle comparison against a period/duty model
// plus directed APB sequences with literal expectations.
module tb_apb_pwm_out;
    import apb_pwm_pkg::*;

    logic        PCLK    = 1'b0;
    logic        PRESETn = 1'b1;
    logic        PSEL    = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE  = 1'b0;
    logic [11:0] PADDR   = '0;
    logic [31:0] PWDATA  = '0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        pwm_out;

    apb_pwm_out #(.DATA_WIDTH(12)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .pwm_out (pwm_out)
    );

    always #5 PCLK = ~PCLK;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    bit          m_en = 0, m_pol = 0, m_wrap = 0, m_pwm = 0, m_slverr = 0;
    logic [11:0] m_per_b = '0, m_dut_b = '0, m_per_s = '0, m_dut_s = '0;
    logic [11:0] m_phase = '0;
    logic [31:0] m_prdata = '0;

    bit          a_wr, a_en_n, a_pol_n, a_wrap_set, a_slverr_n;
    logic [2:0]  a_idx;
    logic [31:0] a_prdata_n;
    int          a_high;

    function automatic logic [31:0] m_read(input logic [2:0] i);
        case (i)
            3'd0:    return {30'd0, m_pol, m_en};
            3'd1:    return {20'd0, m_per_b};
            3'd2:    return {20'd0, m_dut_b};
            3'd3:    return {20'd0, m_phase};
            3'd4:    return {31'd0, m_wrap};
            default: return 32'd0;
        endcase
    endfunction

    initial forever begin
        @(negedge PCLK);
        chk("pwm_out", {31'd0, pwm_out}, {31'd0, m_pwm});
        chk("PRDATA", PRDATA, m_prdata);
        chk("PSLVERR", {31'd0, PSLVERR}, {31'd0, m_slverr});
        chk("PREADY", {31'd0, PREADY}, 32'd1);
        if (!PRESETn) begin
            m_en = 0; m_pol = 0; m_wrap = 0; m_pwm = 0; m_slverr = 0;
            m_per_b = '0; m_dut_b = '0; m_per_s = '0; m_dut_s = '0;
            m_phase = '0; m_prdata = '0;
        end else begin
            a_wr       = PSEL && PENABLE && PWRITE;
            a_idx      = PADDR[4:2];
            a_prdata_n = (PSEL && !PENABLE && !PWRITE) ? m_read(a_idx) : 32'd0;
            a_slverr_n = PSEL && !PENABLE && (a_idx > 3'd4);
            a_en_n     = (a_wr && a_idx == 3'd0) ? PWDATA[0] : m_en;
            a_pol_n    = (a_wr && a_idx == 3'd0) ? PWDATA[1] : m_pol;
            a_wrap_set = 0;
            if (!a_en_n) begin
                m_phase = '0;
                m_pwm   = a_pol_n;
            end else if (!m_en) begin
                m_per_s = m_per_b;
                m_dut_s = m_dut_b;
                m_phase = '0;
                m_pwm   = a_pol_n;
            end else begin
                // high time in a period of P+1 cycles is min(D, P+1)
                a_high = (int'(m_dut_s) > int'(m_per_s)) ? int'(m_per_s) + 1 : int'(m_dut_s);
                m_pwm  = (int'(m_phase) < a_high) ^ a_pol_n;
                if (m_phase == m_per_s) begin
                    a_wrap_set = 1;
                    m_phase    = '0;
                    m_per_s    = m_per_b;
                    m_dut_s    = m_dut_b;
                end else begin
                    m_phase = m_phase + 12'd1;
                end
            end
            if (a_wrap_set)
                m_wrap = 1;
            else if (a_wr && a_idx == 3'd4 && PWDATA[0])
                m_wrap = 0;
            if (a_wr && a_idx == 3'd1) m_per_b = PWDATA[11:0];
            if (a_wr && a_idx == 3'd2) m_dut_b = PWDATA[11:0];
            m_en     = a_en_n;
            m_pol    = a_pol_n;
            m_prdata = a_prdata_n;
            m_slverr = a_slverr_n;
        end
    end

    // ---------------- APB tasks ----------------
    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(negedge PCLK);
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1;
        @(negedge PCLK);
        d   = PRDATA;
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0;
    endtask

    task automatic w(input logic [11:0] a, input logic [31:0] d);
        logic e;
        apb_write(a, d, e);
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(a, d, e);
        chk(nm, d, exp);
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge PCLK);
            h += int'(pwm_out);
        end
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] rdat;
    logic        rerr;
    int          hi;

    initial begin
        #1 PRESETn = 0;
        repeat (3) @(posedge PCLK);
        #2 PRESETn = 1;
        chk("rst_pwm", {31'd0, pwm_out}, 32'd0);
        chk("rst_pready", {31'd0, PREADY}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            apb_read(12'(i * 4), rdat, rerr);
            chk("rst_rd", rdat, 32'd0);
            chk("rst_err", {31'd0, rerr}, (i > 4) ? 32'd1 : 32'd0);
        end

        w(OFF_PERIOD, 32'd9);
        w(OFF_DUTY, 32'd3);
        w(OFF_CTRL, 32'd1);
        rd_chk("rd_period", OFF_PERIOD, 32'd9);
        rd_chk("rd_duty", OFF_DUTY, 32'd3);
        rd_chk("rd_ctrl", OFF_CTRL, 32'd1);
        count_high(20, hi);
        chk("d3_high", 32'(hi), 32'd6);
        rd_chk("wrap_set", OFF_STATUS, 32'd1);

        w(OFF_DUTY, 32'd7);
        repeat (25) @(posedge PCLK);
        count_high(20, hi);
        chk("d7_high", 32'(hi), 32'd14);

        w(OFF_DUTY, 32'd0);
        repeat (25) @(posedge PCLK);
        count_high(20, hi);
        chk("d0_high", 32'(hi), 32'd0);

        w(OFF_DUTY, 32'd12);
        repeat (25) @(posedge PCLK);
        count_high(20, hi);
        chk("d12_high", 32'(hi), 32'd20);

        w(OFF_DUTY, 32'd3);
        w(OFF_CTRL, 32'd3);
        repeat (25) @(posedge PCLK);
        count_high(20, hi);
        chk("pol_high", 32'(hi), 32'd14);

        apb_read(12'h014, rdat, rerr);
        chk("bad_rd_data", rdat, 32'd0);
        chk("bad_rd_err", {31'd0, rerr}, 32'd1);
        apb_write(12'h018, 32'hFFFF_FFFF, rerr);
        chk("bad_wr_err", {31'd0, rerr}, 32'd1);
        apb_write(OFF_CNT, 32'h123, rerr);
        chk("cnt_wr_err", {31'd0, rerr}, 32'd0);
        rd_chk("keep_ctrl", OFF_CTRL, 32'd3);
        rd_chk("keep_period", OFF_PERIOD, 32'd9);
        rd_chk("keep_duty", OFF_DUTY, 32'd3);

        w(OFF_CTRL, 32'd1);
        w(OFF_PERIOD, 32'd0);
        repeat (15) @(posedge PCLK);
        count_high(10, hi);
        chk("p0_high", 32'(hi), 32'd10);
        w(OFF_STATUS, 32'd1);
        rd_chk("p0_wrap_sticky", OFF_STATUS, 32'd1);

        w(OFF_PERIOD, 32'd9);
        repeat (15) @(posedge PCLK);
        w(OFF_CTRL, 32'd0);
        @(negedge PCLK);
        chk("dis_pwm", {31'd0, pwm_out}, 32'd0);
        rd_chk("dis_cnt", OFF_CNT, 32'd0);
        w(OFF_STATUS, 32'd1);
        rd_chk("w1c_clear", OFF_STATUS, 32'd0);

        w(OFF_PERIOD, 32'd5);
        w(OFF_CTRL, 32'd1);
        repeat (3) @(posedge PCLK);
        @(posedge PCLK); #1;
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = OFF_DUTY; PWDATA = 32'd9;
        @(posedge PCLK); #1;
        PENABLE = 1;
        #2 PRESETn = 0;
        @(posedge PCLK); #2;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PRESETn = 1;
        chk("arst_pwm", {31'd0, pwm_out}, 32'd0);
        rd_chk("arst_ctrl", OFF_CTRL, 32'd0);
        rd_chk("arst_period", OFF_PERIOD, 32'd0);
        rd_chk("arst_duty", OFF_DUTY, 32'd0);
        rd_chk("arst_status", OFF_STATUS, 32'd0);
        rd_chk("arst_cnt", OFF_CNT, 32'd0);

        repeat (5) @(posedge PCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of sequence");
        $fatal(1, "timeout");
    end

endmodule
